// File: rtl/ms_countdown_pkg.sv
// ms_countdown_pkg: shared state encoding, LED patterns and default tick length for ms_countdown
package ms_countdown_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        EXPIRED
    } state_t;

    localparam logic [9:0] LED_ALL_ON  = 10'h3FF;
    localparam logic [9:0] LED_ALL_OFF = 10'h000;
    localparam int         MS_DEFAULT  = 50000;

endpackage

// File: rtl/ms_prescaler.sv
// ms_prescaler: free-running 0..MS-1 cycle counter producing a one-cycle millisecond tick
module ms_prescaler
    import ms_countdown_pkg::*;
#(
    parameter int MS = MS_DEFAULT
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (MS > 1) ? $clog2(MS) : 1;

    logic [CW-1:0] r_cnt;

    assign tick = en && (r_cnt == CW'(MS - 1));

    // count while enabled, wrap on the tick cycle; clear has priority
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= '0;
        else if (en)
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/ms_countdown.sv
// ms_countdown: millisecond countdown timer with sticky expiry flag and LED indication
// Optional blinking LEDs in the expired state: define MS_COUNTDOWN_BLINK_EN.
module ms_countdown
    import ms_countdown_pkg::*;
#(
    parameter int MS       = MS_DEFAULT,
    parameter int W        = 11,
    parameter int BLINK_MS = 250
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         pause,
    input  logic         ack,
    output logic [W-1:0] remaining,
    output logic         busy,
    output logic         expired,
    output logic [9:0]   LED
);

    if (BLINK_MS < 1) begin : g_bad_blink
        $error("BLINK_MS must be at least 1");
    end

    state_t       r_state;
    state_t       w_nxt;
    logic [W-1:0] w_rem;
    logic         w_run;
    logic         w_exp;
    logic         w_tick;
    logic         w_en;
    logic         w_clr;

    assign w_run = (r_state == RUN) || (r_state == PAUSE);
    assign w_exp = (r_state == EXPIRED);

`ifdef MS_COUNTDOWN_BLINK_EN
    localparam int BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

    logic [BW-1:0] r_blink;

    // in EXPIRED the prescaler keeps running to pace the LED blink
    assign w_en  = (w_run && !pause) || (w_exp && !ack);
    assign w_clr = load || (r_state == IDLE) || (w_exp && ack);
`else
    assign w_en  = w_run && !pause;
    assign w_clr = load || (r_state == IDLE) || w_exp;
`endif

    ms_prescaler #(.MS(MS)) u_prescaler (
        .CLK   (CLK),
        .RST_N (RST_N),
        .en    (w_en),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    // next state and count: load > ack > pause > tick
    always_comb begin
        w_nxt = r_state;
        w_rem = remaining;
        if (load) begin
            w_rem = value;
            w_nxt = (value != '0) ? RUN : EXPIRED;
        end else if (ack && w_exp) begin
            w_nxt = IDLE;
            w_rem = '0;
        end else if (w_run) begin
            w_nxt = pause ? PAUSE : (w_tick && remaining <= W'(1)) ? EXPIRED : RUN;
            w_rem = (pause || !w_tick) ? remaining : (remaining > W'(1)) ? remaining - 1'b1 : '0;
        end
    end

    // state register with outputs registered from the next state
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            expired   <= 1'b0;
            LED       <= LED_ALL_OFF;
`ifdef MS_COUNTDOWN_BLINK_EN
            r_blink   <= '0;
`endif
        end else begin
            r_state   <= w_nxt;
            remaining <= w_rem;
            busy      <= (w_nxt == RUN) || (w_nxt == PAUSE);
            expired   <= (w_nxt == EXPIRED);
`ifdef MS_COUNTDOWN_BLINK_EN
            if (w_exp && w_nxt == EXPIRED && !load) begin
                if (w_tick) begin
                    r_blink <= (r_blink == BW'(BLINK_MS - 1)) ? '0 : r_blink + 1'b1;
                    LED     <= (r_blink == BW'(BLINK_MS - 1)) ? ~LED : LED;
                end
            end else begin
                r_blink <= '0;
                LED     <= (w_nxt == EXPIRED) ? LED_ALL_ON : LED_ALL_OFF;
            end
`else
            LED       <= (w_nxt == EXPIRED) ? LED_ALL_ON : LED_ALL_OFF;
`endif
        end
    end

endmodule

// File: doc/ms_countdown.md
# ms_countdown

Millisecond countdown timer for the reaction-timer board design. It loads an 11-bit millisecond value and decrements it once per millisecond from an internal prescaler on the 50 MHz board clock. It asserts a sticky expiry flag and drives the 10 LEDs when the count reaches zero. It is the down-counting counterpart of the up-counting millisecond clock divider: it generates the timed event that the elapsed-time counter measures against.

## Interface
- MS, 50000: clock cycles per millisecond tick.
- W, 11: width of the millisecond count.
- BLINK_MS, 250: LED half-period in ms in the expired state; used only with blink enabled.
- CLK  in  1  system clock; all state changes on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle pulse; starts or restarts the countdown from `value`.
- value  in  W  countdown length in ms; sampled only when `load`=1.
- pause  in  1  level; freezes the countdown and the prescaler while high.
- ack  in  1  one-cycle pulse; clears the expired state.
- remaining  out  W  current count in ms; registered.
- busy  out  1  high in RUN and PAUSE; registered.
- expired  out  1  high in EXPIRED; registered; sticky until `ack` or `load`.
- LED  out  10  expiry indication; registered.

## Operation
- States:
  - IDLE: reset state.
  - RUN: counting.
  - PAUSE: frozen.
  - EXPIRED: count reached zero.
- Reset (asynchronous, takes effect immediately):
  - State = IDLE; prescaler = 0.
  - `remaining`=0, `busy`=0, `expired`=0, `LED`=10'h000.
- Input priority each cycle: `load` > `ack` > `pause` > tick.
- `load` in any state:
  - Prescaler is cleared to 0 and `remaining` is set to `value`.
  - If `value`≠0, next state is RUN.
  - If `value`=0, next state is EXPIRED.
- Prescaler:
  - Counts 0..MS-1 while in RUN.
  - Asserts an internal tick on the cycle where it equals MS-1, then wraps to 0.
  - Holds its value in PAUSE; it is not cleared.
  - Held at 0 in IDLE.
- RUN:
  - On a tick with `remaining`>1, `remaining` decrements by 1.
  - On a tick with `remaining`=1, `remaining` becomes 0 and the next state is EXPIRED.
  - `remaining` never wraps below 0.
- RUN with `pause`=1 goes to PAUSE. PAUSE with `pause`=0 returns to RUN, and the prescaler resumes from its held value.
- `ack` in EXPIRED goes to IDLE with `remaining` held at 0. `ack` in any other state is ignored.
- `LED` is 10'h000 in IDLE, RUN and PAUSE. In EXPIRED it follows the Configuration section.

## Timing
- All outputs are registered and update on the edge that changes the state.
- `load` sampled at edge k:
  - `remaining`=`value` and `busy`=1 are visible after edge k.
  - The first decrement happens at edge k+MS.
- Expiry (no pause) happens at edge k+`value`·MS. On that edge `expired` rises, `busy` falls, `remaining`=0 and `LED` takes its expired pattern.
- Each cycle spent in PAUSE delays expiry by exactly one cycle.
- `load` with `value`=0 gives `expired`=1 after edge k.
- `ack` at edge k gives `expired`=0 and `LED`=0 after edge k.
- `load` and `ack` in the same cycle: `load` wins.
- `pause` high in the same cycle as `load`: the block enters RUN, then PAUSE on the next edge if `pause` is still high.

## Configuration
- Macro: `MS_COUNTDOWN_BLINK_EN`.
- With the macro defined:
  - In EXPIRED the prescaler keeps running and feeds a blink counter.
  - `LED` is 10'h3FF on entry to EXPIRED and toggles to 10'h000 and back every BLINK_MS ms.
  - The blink counter clears on leaving EXPIRED.
- Without the macro:
  - `LED` is a solid 10'h3FF throughout EXPIRED.
  - No blink counter is built, and the prescaler is held at 0 in EXPIRED.

## Structure
- Package `ms_countdown_pkg` holds:
  - The state enum: IDLE, RUN, PAUSE, EXPIRED.
  - `LED_ALL_ON` = 10'h3FF and `LED_ALL_OFF` = 10'h000.
  - The default `MS` constant.
- Sub-module `ms_prescaler` (parameter MS):
  - Inputs `en` and `clr`; output `tick`.
  - The counter register is sized to hold MS-1.
  - It is instantiated once. The FSM, `remaining` and `LED` logic stay in the top module.

## Test plan
Run with MS=4 and BLINK_MS=2.
- Basic countdown: `load` with `value`=3 at edge 0 → `remaining` reads 3, 2, 1 after edges 0, 4, 8; at edge 12 `remaining`=0, `expired`=1, `busy`=0, `LED`=3FF (solid build).
- Pause: `load` with `value`=2, then `pause`=1 for 10 cycles starting when the prescaler is at 2 → expiry at edge 18 instead of 8; `remaining` does not change while paused.
- Zero load: `load` with `value`=0 from IDLE → `expired`=1, `busy`=0 after one edge. Then `ack` → IDLE with all outputs 0.
- Simultaneous `load` and `ack` in EXPIRED, `value`=5 → RUN, `remaining`=5, `expired`=0. Also assert RST_N low mid-RUN between clock edges → all outputs 0 immediately.
- Blink with `MS_COUNTDOWN_BLINK_EN` defined, `value`=1 → `LED`=3FF for 8 cycles, 000 for 8 cycles, 3FF for 8 cycles, repeating until `ack`.
